// File: rtl/hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_driver
// Description : 1/32-scan HUB75 driver reading a 64x64 RGB framebuffer and
//               emitting binary-coded-modulation bit planes, LSB plane first.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_driver #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int BIT_DEPTH  = 8,
  parameter int BASE_TICKS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r1,
  output logic                  g1,
  output logic                  b1,
  output logic                  r2,
  output logic                  g2,
  output logic                  b2,
  output logic [4:0]            row_addr,
  output logic                  sclk,
  output logic                  lat,
  output logic                  oe_n,
  output logic                  frame_tick
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

  localparam logic [2:0] c_last_plane = 3'(BIT_DEPTH - 1);
  localparam logic [2:0] c_bit_base   = 3'(8 - BIT_DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [4:0]            r_row;
  logic [2:0]            r_plane;
  logic [5:0]            r_col;
  logic [1:0]            r_phase;
  logic [12:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_upper;
  logic [2:0]            w_bit;
  logic [11:0]           w_addr;
  logic                  w_shift_done;
  logic                  w_disp_done;

  assign w_bit        = c_bit_base + r_plane;
  assign w_shift_done = (r_col == 6'd63) && (r_phase == 2'd3);
  assign w_disp_done  = (r_cnt == 13'd1);
  assign r_addr       = ADDR_WIDTH'(w_addr);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_addr     = '0;
    sclk       = 1'b0;
    lat        = 1'b0;
    oe_n       = 1'b1;
    frame_tick = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        sclk = (r_phase == 2'd3);
        // Upper row first, lower row (y = row + 32) one cycle later
        if (r_phase == 2'd0)      w_addr = {1'b0, r_row, r_col};
        else if (r_phase == 2'd1) w_addr = {1'b1, r_row, r_col};
        if (!enable)           w_next = ST_IDLE;
        else if (w_shift_done) w_next = ST_BLANK;
      end
      ST_BLANK: begin
        w_next = enable ? ST_LATCH : ST_IDLE;
      end
      ST_LATCH: begin
        lat    = 1'b1;
        w_next = enable ? ST_DISPLAY : ST_IDLE;
      end
      ST_DISPLAY: begin
        oe_n = 1'b0;
        if (w_disp_done) begin
          w_next     = enable ? ST_SHIFT : ST_IDLE;
          frame_tick = (r_plane == c_last_plane) && (r_row == 5'd31);
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row    <= '0;
      r_plane  <= '0;
      r_col    <= '0;
      r_phase  <= '0;
      r_cnt    <= '0;
      r_upper  <= '0;
      row_addr <= '0;
      {r1, g1, b1, r2, g2, b2} <= '0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_phase <= r_phase + 2'd1;
          if (r_phase == 2'd3) r_col <= r_col + 6'd1;
          if (r_phase == 2'd1) r_upper <= r_data;
          if (r_phase == 2'd2) begin
            r1 <= r_upper[{2'b10, w_bit}];
            g1 <= r_upper[{2'b01, w_bit}];
            b1 <= r_upper[{2'b00, w_bit}];
            r2 <= r_data[{2'b10, w_bit}];
            g2 <= r_data[{2'b01, w_bit}];
            b2 <= r_data[{2'b00, w_bit}];
          end
        end
        ST_BLANK: row_addr <= r_row;
        ST_LATCH: r_cnt <= 13'(BASE_TICKS) << r_plane;
        ST_DISPLAY: begin
          r_cnt <= r_cnt - 13'd1;
          if (w_disp_done) begin
            if (r_plane == c_last_plane) begin
              r_plane <= '0;
              r_row   <= r_row + 5'd1;
            end else begin
              r_plane <= r_plane + 3'd1;
            end
          end
        end
        default: ;
      endcase
      // Any return to idle makes the next enable start a fresh frame
      if (w_next == ST_IDLE) begin
        r_row   <= '0;
        r_plane <= '0;
        r_col   <= '0;
        r_phase <= '0;
        {r1, g1, b1, r2, g2, b2} <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_driver
// Description : Self-checking bench for hub75_scan_driver with a behavioural
//               framebuffer and panel-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_driver;

  localparam int TB_BD   = 4;
  localparam int TB_BASE = 2;
  localparam int FRAME   = 32 * (TB_BD * 258 + TB_BASE * ((1 << TB_BD) - 1));

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] r_addr;
  logic [23:0] r_data;
  logic        r1, g1, b1, r2, g2, b2;
  logic [4:0]  row_addr;
  logic        sclk, lat, oe_n, frame_tick;

  logic [23:0] mem [0:4095];
  int          errors = 0;
  int          checks = 0;

  logic [2:0]  obs_u [64];
  logic [2:0]  obs_l [64];
  int          obs_sclk, obs_lat, obs_on;
  logic [4:0]  obs_row;

  hub75_scan_driver #(
    .ADDR_WIDTH(12), .DATA_WIDTH(24), .BIT_DEPTH(TB_BD), .BASE_TICKS(TB_BASE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .r_addr(r_addr), .r_data(r_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .sclk(sclk), .lat(lat), .oe_n(oe_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) r_data <= mem[r_addr];

  // Expected {R,G,B} bits of a pixel shown during BCM plane p
  function automatic logic [2:0] colour_bits(logic [23:0] px, int p);
    int k;
    k = 8 - TB_BD + p;
    return {px[16 + k], px[8 + k], px[k]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 24'h0;
  endtask

  task automatic random_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 24'($urandom);
  endtask

  task automatic restart();
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
  endtask

  // Records one shift/latch/display pass as seen on the panel pins
  task automatic observe_pass();
    int cyc;
    obs_sclk = 0; obs_lat = 0; obs_on = 0; obs_row = 5'h1f; cyc = 0;
    for (int i = 0; i < 64; i++) begin obs_u[i] = 3'bxxx; obs_l[i] = 3'bxxx; end
    while (obs_lat == 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (sclk) begin
        if (obs_sclk < 64) begin
          obs_u[obs_sclk] = {r1, g1, b1};
          obs_l[obs_sclk] = {r2, g2, b2};
        end
        obs_sclk++;
      end
      if (lat) begin obs_lat++; obs_row = row_addr; end
    end
    while (cyc < 3000) begin
      @(negedge clk); cyc++;
      if (lat) obs_lat++;
      if (!oe_n) obs_on++;
      else if (obs_on > 0) break;
    end
    if (cyc >= 3000) begin
      checks++; errors++;
      $display("FAIL pass_timeout got=%0d cycles want=<3000", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({oe_n, sclk, lat, frame_tick} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=1000", {oe_n, sclk, lat, frame_tick});
    end
    checks++;
    if ({r1, g1, b1, r2, g2, b2} !== 6'b0) begin
      errors++; $display("FAIL reset_colour got=%b want=000000", {r1, g1, b1, r2, g2, b2});
    end
    checks++;
    if ({r_addr, row_addr} !== 17'h0) begin
      errors++; $display("FAIL reset_addr got=%h/%h want=0/0", r_addr, row_addr);
    end
  endtask

  task automatic test_zero_frame();
    int nz;
    clear_mem();
    restart();
    for (int p = 0; p < TB_BD; p++) begin
      observe_pass();
      nz = 0;
      for (int c = 0; c < 64; c++) if ((obs_u[c] | obs_l[c]) !== 3'b0) nz++;
      checks++;
      if (obs_sclk !== 64) begin errors++; $display("FAIL zero_sclk p=%0d got=%0d want=64", p, obs_sclk); end
      checks++;
      if (obs_lat !== 1) begin errors++; $display("FAIL zero_lat p=%0d got=%0d want=1", p, obs_lat); end
      checks++;
      if (obs_on !== (TB_BASE << p)) begin
        errors++; $display("FAIL zero_on p=%0d got=%0d want=%0d", p, obs_on, TB_BASE << p);
      end
      checks++;
      if (nz !== 0 || obs_row !== 5'd0) begin
        errors++; $display("FAIL zero_data p=%0d got=nz%0d/row%0d want=0/0", p, nz, obs_row);
      end
    end
  endtask

  task automatic test_corner_pixels();
    clear_mem();
    mem[0] = 24'hFF0000;
    mem[32 * 64] = 24'h0000FF;
    restart();
    for (int p = 0; p < TB_BD; p++) begin
      observe_pass();
      checks++;
      if ({obs_u[0], obs_l[0]} !== 6'b100_001) begin
        errors++; $display("FAIL corner_col0 p=%0d got=%b want=100001", p, {obs_u[0], obs_l[0]});
      end
      checks++;
      if ({obs_u[1], obs_l[1]} !== 6'b0) begin
        errors++; $display("FAIL corner_col1 p=%0d got=%b want=000000", p, {obs_u[1], obs_l[1]});
      end
    end
  endtask

  task automatic test_single_bit();
    int hits, want;
    clear_mem();
    mem[5 * 64 + 3] = 24'h800000;
    restart();
    for (int r = 0; r <= 5; r++) begin
      for (int p = 0; p < TB_BD; p++) begin
        observe_pass();
        hits = 0;
        for (int c = 0; c < 64; c++) if ((obs_u[c] | obs_l[c]) !== 3'b0) hits++;
        want = (r == 5 && p == TB_BD - 1) ? 1 : 0;
        checks++;
        if (hits !== want) begin
          errors++; $display("FAIL single_hits r=%0d p=%0d got=%0d want=%0d", r, p, hits, want);
        end
        if (want == 1) begin
          checks++;
          if (obs_u[3] !== 3'b100 || obs_on !== (TB_BASE << (TB_BD - 1))) begin
            errors++;
            $display("FAIL single_pixel got=%b/on%0d want=100/on%0d", obs_u[3], obs_on, TB_BASE << (TB_BD - 1));
          end
        end
      end
    end
  endtask

  task automatic test_random_rows();
    int bad;
    random_mem();
    restart();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < TB_BD; p++) begin
        observe_pass();
        bad = 0;
        for (int c = 0; c < 64; c++) begin
          if (obs_u[c] !== colour_bits(mem[r * 64 + c], p)) bad++;
          if (obs_l[c] !== colour_bits(mem[(r + 32) * 64 + c], p)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rand_bits r=%0d p=%0d got=%0d bad want=0", r, p, bad); end
        checks++;
        if (obs_row !== 5'(r) || obs_on !== (TB_BASE << p)) begin
          errors++;
          $display("FAIL rand_timing r=%0d p=%0d got=row%0d/on%0d want=row%0d/on%0d",
                   r, p, obs_row, obs_on, r, TB_BASE << p);
        end
      end
    end
  endtask

  task automatic test_free_run();
    int n, tick_at, lats, sclks, bad_change, bad_seq;
    int rows_q[$];
    logic [4:0] prev;
    random_mem();
    restart();
    n = 0; tick_at = -1; lats = 0; sclks = 0; bad_change = 0; prev = 5'd0;
    while (n < FRAME + 200) begin
      @(negedge clk); n++;
      if (sclk) sclks++;
      if (lat) begin lats++; rows_q.push_back(int'(row_addr)); end
      if (row_addr !== prev && !lat) bad_change++;
      prev = row_addr;
      if (frame_tick) begin tick_at = n; break; end
    end
    checks++;
    if (tick_at !== FRAME) begin errors++; $display("FAIL frame_len got=%0d want=%0d", tick_at, FRAME); end
    checks++;
    if (lats !== 32 * TB_BD || sclks !== 32 * TB_BD * 64) begin
      errors++; $display("FAIL frame_counts got=lat%0d/sclk%0d want=lat%0d/sclk%0d",
                         lats, sclks, 32 * TB_BD, 32 * TB_BD * 64);
    end
    bad_seq = 0;
    foreach (rows_q[i]) if (rows_q[i] != i / TB_BD) bad_seq++;
    checks++;
    if (bad_seq !== 0 || bad_change !== 0) begin
      errors++; $display("FAIL row_seq got=seq%0d/chg%0d want=0/0", bad_seq, bad_change);
    end
    observe_pass();
    checks++;
    if (obs_row !== 5'd0 || obs_on !== TB_BASE) begin
      errors++; $display("FAIL row_wrap got=row%0d/on%0d want=row0/on%0d", obs_row, obs_on, TB_BASE);
    end
  endtask

  task automatic test_enable_drop();
    int cnt, guard, bad, act;
    random_mem();
    restart();
    for (int p = 0; p < TB_BD; p++) observe_pass();
    cnt = 0; guard = 0;
    while (cnt < 20 && guard < 1000) begin
      @(negedge clk); guard++;
      if (sclk) cnt++;
    end
    checks++;
    if (cnt !== 20) begin errors++; $display("FAIL drop_wait got=%0d want=20", cnt); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({oe_n, sclk, lat} !== 3'b100) begin
      errors++; $display("FAIL drop_park got=%b want=100", {oe_n, sclk, lat});
    end
    act = 0;
    repeat (6) begin @(negedge clk); if (sclk || lat || !oe_n) act++; end
    checks++;
    if (act !== 0) begin errors++; $display("FAIL drop_idle got=%0d active want=0", act); end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (r_addr !== 12'h000) begin errors++; $display("FAIL drop_first_addr got=%h want=000", r_addr); end
    observe_pass();
    bad = 0;
    for (int c = 0; c < 64; c++)
      if (obs_u[c] !== colour_bits(mem[c], 0) || obs_l[c] !== colour_bits(mem[32 * 64 + c], 0)) bad++;
    checks++;
    if (obs_row !== 5'd0 || obs_on !== TB_BASE || bad !== 0) begin
      errors++; $display("FAIL drop_restart got=row%0d/on%0d/bad%0d want=row0/on%0d/bad0",
                         obs_row, obs_on, bad, TB_BASE);
    end
  endtask

  task automatic test_reset_display();
    int guard, bad;
    random_mem();
    restart();
    for (int p = 0; p < TB_BD; p++) observe_pass();
    guard = 0;
    while (oe_n && guard < 1000) begin @(negedge clk); guard++; end
    checks++;
    if (oe_n !== 1'b0 || row_addr !== 5'd1) begin
      errors++; $display("FAIL rstdisp_reach got=oe%b/row%0d want=oe0/row1", oe_n, row_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({oe_n, lat, row_addr} !== 7'b10_00000) begin
      errors++; $display("FAIL rstdisp_out got=oe%b/lat%b/row%0d want=oe1/lat0/row0", oe_n, lat, row_addr);
    end
    reset = 1'b0;
    observe_pass();
    bad = 0;
    for (int c = 0; c < 64; c++)
      if (obs_u[c] !== colour_bits(mem[c], 0) || obs_l[c] !== colour_bits(mem[32 * 64 + c], 0)) bad++;
    checks++;
    if (obs_row !== 5'd0 || obs_on !== TB_BASE || obs_lat !== 1 || bad !== 0) begin
      errors++; $display("FAIL rstdisp_restart got=row%0d/on%0d/lat%0d/bad%0d want=row0/on%0d/lat1/bad0",
                         obs_row, obs_on, obs_lat, bad, TB_BASE);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_zero_frame();
    test_corner_pixels();
    test_single_bit();
    test_random_rows();
    test_free_run();
    test_enable_drop();
    test_reset_display();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
